// File: rtl/bp_pkg.sv
// Shared defaults, queue-entry type and constants for the branch predictor slice.
// GSHARE_GHR_EN adds the global-history snapshot field to each queue entry.
package bp_pkg;

    localparam int unsigned BP_BHT_IDX_W = 6;
    localparam int unsigned BP_CTR_W     = 2;
    localparam int unsigned BP_GHR_W     = 6;
    localparam int unsigned BP_Q_DEPTH_W = 3;

    // Entry fields are sized for the largest supported index/history width.
    localparam int unsigned BP_IDX_MAX_W = 16;

    localparam logic [31:0] BP_OFFSET_4B = 32'd4;
    localparam logic [31:0] BP_OFFSET_2B = 32'd2;

    typedef struct packed {
        logic [31:0]             pc;
        logic [31:0]             alt;
        logic                    pred;
        logic [BP_IDX_MAX_W-1:0] idx;
`ifdef GSHARE_GHR_EN
        logic [BP_IDX_MAX_W-1:0] ghr;
`endif
    } bp_entry_t;

    // Weakly-not-taken reset value for a counter of width w.
    function automatic logic [3:0] ctr_init(input int unsigned w);
        return 4'((1 << (w - 1)) - 1);
    endfunction

    // Smallest counter value that predicts taken.
    function automatic logic [3:0] ctr_thresh(input int unsigned w);
        return 4'(1 << (w - 1));
    endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// Circular queue of unresolved predictions with push, pop and flush.
// Field layout depends on GSHARE_GHR_EN through bp_entry_t.
module bp_inflight_fifo
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH_W = BP_Q_DEPTH_W
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  bp_entry_t        wdata,
    output bp_entry_t        head,
    output logic [DEPTH_W:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_W;

    bp_entry_t          mem_q [DEPTH];
    bp_entry_t          mem_d [DEPTH];
    logic [DEPTH_W-1:0] front_q, front_d;
    logic [DEPTH_W-1:0] rear_q, rear_d;
    logic [DEPTH_W:0]   count_q, count_d;

    always_comb begin
        front_d = front_q;
        rear_d  = rear_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (flush) begin
            front_d = '0;
            rear_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[rear_q] = wdata;
                rear_d        = rear_q + DEPTH_W'(1);
            end
            if (pop) front_d = front_q + DEPTH_W'(1);
            if (push && !pop) count_d = count_q + (DEPTH_W+1)'(1);
            else if (pop && !push) count_d = count_q - (DEPTH_W+1)'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            front_q <= '0;
            rear_q  <= '0;
            count_q <= '0;
            mem_q   <= '{default: '0};
        end else begin
            front_q <= front_d;
            rear_q  <= rear_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    assign head  = mem_q[front_q];
    assign count = count_q;
    assign full  = (count_q == (DEPTH_W+1)'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/gshare_predictor.sv
// Branch predictor: 2^BHT_IDX_W saturating counters, in-flight queue resolved by CDB.
// Define GSHARE_GHR_EN for gshare indexing with speculative history; default is bimodal.
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int unsigned BHT_IDX_W = BP_BHT_IDX_W,
    parameter int unsigned CTR_W     = BP_CTR_W,
    parameter int unsigned GHR_W     = BP_GHR_W,
    parameter int unsigned Q_DEPTH_W = BP_Q_DEPTH_W
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        branch_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] imm_in,
    input  logic        inst_length_in,
    input  logic        cdb_active,
    input  logic [31:0] cdb_addr,
    input  logic [31:0] cdb_val,
    output logic        need_branch,
    output logic [31:0] branch_addr,
    output logic        bp_full,
    output logic        predict_fail,
    output logic [31:0] fail_addr
);

    localparam int unsigned      BHT_SIZE = 1 << BHT_IDX_W;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_init(CTR_W));
    localparam logic [CTR_W-1:0] CTR_SAT  = '1;

    logic [CTR_W-1:0]     ctr_q [BHT_SIZE];
    logic [CTR_W-1:0]     ctr_d [BHT_SIZE];
    bp_entry_t            head;
    bp_entry_t            wdata;
    logic [Q_DEPTH_W:0]   q_count;
    logic                 q_full, q_empty;
    logic [BHT_IDX_W-1:0] idx, upd_idx;
    logic                 accept, pred, hit, fail;
    logic [31:0]          seq_addr, tgt_addr;

`ifdef GSHARE_GHR_EN
    logic [GHR_W-1:0] ghr_q, ghr_d;

    always_comb idx = pc_in[BHT_IDX_W:1] ^ BHT_IDX_W'(ghr_q);

    // A mispredict restores the head's snapshot and appends the real outcome,
    // which also discards any same-cycle speculative shift.
    always_comb begin
        ghr_d = ghr_q;
        if (fail)        ghr_d = GHR_W'({head.ghr, cdb_val[0]});
        else if (accept) ghr_d = GHR_W'({ghr_q, pred});
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) ghr_q <= '0;
        else         ghr_q <= ghr_d;
    end

    logic unused_ghr_bits;
    assign unused_ghr_bits = ^{head.ghr};
`else
    always_comb idx = pc_in[BHT_IDX_W:1];

    logic unused_ghr_bits;
    assign unused_ghr_bits = ^{GHR_W[0]};
`endif

    // Outputs are gated by rst_in so they drop as soon as reset asserts.
    always_comb begin
        accept   = rst_in && rdy_in && branch_in && !q_full;
        pred     = accept && ctr_q[idx][CTR_W-1];
        seq_addr = pc_in + (inst_length_in ? BP_OFFSET_4B : BP_OFFSET_2B);
        tgt_addr = pc_in + imm_in;
        hit      = rst_in && rdy_in && cdb_active && !q_empty && (cdb_addr == head.pc);
        fail     = hit && (head.pred != cdb_val[0]);
        upd_idx  = head.idx[BHT_IDX_W-1:0];

        wdata      = '0;
        wdata.pc   = pc_in;
        wdata.alt  = pred ? seq_addr : tgt_addr;
        wdata.pred = pred;
        wdata.idx  = BP_IDX_MAX_W'(idx);
`ifdef GSHARE_GHR_EN
        wdata.ghr  = BP_IDX_MAX_W'(ghr_q);
`endif
    end

    always_comb begin
        ctr_d = ctr_q;
        if (hit) begin
            if (cdb_val[0]) begin
                if (ctr_q[upd_idx] != CTR_SAT) ctr_d[upd_idx] = ctr_q[upd_idx] + CTR_W'(1);
            end else begin
                if (ctr_q[upd_idx] != '0) ctr_d[upd_idx] = ctr_q[upd_idx] - CTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) ctr_q <= '{default: CTR_INIT};
        else         ctr_q <= ctr_d;
    end

    bp_inflight_fifo #(
        .DEPTH_W (Q_DEPTH_W)
    ) u_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .push   (accept),
        .pop    (hit),
        .flush  (fail),
        .wdata  (wdata),
        .head   (head),
        .count  (q_count),
        .full   (q_full),
        .empty  (q_empty)
    );

    assign need_branch  = pred;
    assign branch_addr  = accept ? (pred ? tgt_addr : seq_addr) : '0;
    assign bp_full      = q_full;
    assign predict_fail = fail;
    assign fail_addr    = fail ? head.alt : '0;

    logic unused_ok;
    assign unused_ok = ^{pc_in[31:BHT_IDX_W+1], pc_in[0], cdb_val[31:1],
                         head.idx[BP_IDX_MAX_W-1:BHT_IDX_W], q_count};

endmodule

// File: tb/tb_gshare_predictor.sv
// Randomized bench for gshare_predictor against a queue-based reference model.
// Follows GSHARE_GHR_EN the same way the design does.
module tb_gshare_predictor;

    localparam int unsigned IDX_W  = 6;
    localparam int unsigned CTR_W  = 2;
    localparam int unsigned GHR_W  = 6;
    localparam int unsigned QD_W   = 3;
    localparam int unsigned NCTR   = 1 << IDX_W;
    localparam int unsigned QDEPTH = 1 << QD_W;
    localparam int unsigned CMAX   = (1 << CTR_W) - 1;
    localparam int unsigned CTHR   = 1 << (CTR_W - 1);
    localparam int unsigned GMASK  = (1 << GHR_W) - 1;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b0;
    logic        branch_in = 1'b0;
    logic        inst_length_in = 1'b0;
    logic        cdb_active = 1'b0;
    logic [31:0] pc_in = '0, imm_in = '0, cdb_addr = '0, cdb_val = '0;
    logic        need_branch, bp_full, predict_fail;
    logic [31:0] branch_addr, fail_addr;

    gshare_predictor #(
        .BHT_IDX_W (IDX_W),
        .CTR_W     (CTR_W),
        .GHR_W     (GHR_W),
        .Q_DEPTH_W (QD_W)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .branch_in      (branch_in),
        .pc_in          (pc_in),
        .imm_in         (imm_in),
        .inst_length_in (inst_length_in),
        .cdb_active     (cdb_active),
        .cdb_addr       (cdb_addr),
        .cdb_val        (cdb_val),
        .need_branch    (need_branch),
        .branch_addr    (branch_addr),
        .bp_full        (bp_full),
        .predict_fail   (predict_fail),
        .fail_addr      (fail_addr)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] alt;
        bit          pred;
        int unsigned idx;
        int unsigned ghr;
    } ent_t;

    int unsigned m_ctr [NCTR];
    int unsigned m_ghr;
    ent_t        m_q [$];

    int n_checks = 0;
    int n_errors = 0;

    logic        o_nb, o_full, o_pf;
    logic [31:0] o_ba, o_fa;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_ctr[i]) m_ctr[i] = CTHR - 1;
        m_ghr = 0;
        m_q.delete();
    endtask

    // One clock cycle: drive, compare combinational outputs, then advance the model.
    task automatic step(input bit rdy, input bit br, input logic [31:0] pc, input logic [31:0] imm,
                        input bit len, input bit cdb, input logic [31:0] caddr, input bit taken);
        int unsigned idx;
        bit          full, acc, pred, hit, fail;
        logic [31:0] seq, tgt, e_ba, e_fa;
        ent_t        h, e;
        rdy_in = rdy; branch_in = br; pc_in = pc; imm_in = imm; inst_length_in = len;
        cdb_active = cdb; cdb_addr = caddr;
        cdb_val = ($urandom() & 32'hFFFF_FFFE) | {31'd0, taken};
        #1;
        full = (m_q.size() == QDEPTH);
`ifdef GSHARE_GHR_EN
        idx = ((pc >> 1) % NCTR) ^ m_ghr;
`else
        idx = (pc >> 1) % NCTR;
`endif
        acc  = rdy && br && !full;
        pred = acc && (m_ctr[idx] >= CTHR);
        seq  = pc + (len ? 32'd4 : 32'd2);
        tgt  = pc + imm;
        e_ba = !acc ? 32'd0 : (pred ? tgt : seq);
        hit  = rdy && cdb && (m_q.size() > 0) && (caddr == m_q[0].pc);
        fail = hit && (m_q[0].pred != taken);
        e_fa = fail ? m_q[0].alt : 32'd0;

        o_nb = need_branch; o_ba = branch_addr; o_full = bp_full;
        o_pf = predict_fail; o_fa = fail_addr;
        check("need_branch", o_nb, pred);
        check("branch_addr", o_ba, e_ba);
        check("bp_full", o_full, full);
        check("predict_fail", o_pf, fail);
        check("fail_addr", o_fa, e_fa);

        @(posedge clk_in);
        if (hit) begin
            h = m_q.pop_front();
            if (taken && m_ctr[h.idx] < CMAX) m_ctr[h.idx]++;
            else if (!taken && m_ctr[h.idx] > 0) m_ctr[h.idx]--;
        end
        if (fail) begin
            m_q.delete();
            m_ghr = ((h.ghr << 1) | taken) & GMASK;
        end else if (acc) begin
            e.pc = pc; e.alt = pred ? seq : tgt; e.pred = pred; e.idx = idx; e.ghr = m_ghr;
            m_q.push_back(e);
            m_ghr = ((m_ghr << 1) | pred) & GMASK;
        end
        #1;
    endtask

    task automatic idle();
        step(1, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0);
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] imm);
        step(1, 1, pc, imm, 1, 0, 32'h0, 0);
    endtask

    task automatic resolve(input logic [31:0] pc, input bit taken);
        step(1, 0, 32'h0, 32'h0, 0, 1, pc, taken);
    endtask

    // Reset with busy inputs so the forced-zero outputs are exercised.
    task automatic do_reset();
        rst_in = 1'b0; rdy_in = 1'b1; branch_in = 1'b1; pc_in = 32'h100; imm_in = 32'h20;
        inst_length_in = 1'b1; cdb_active = 1'b1; cdb_addr = 32'h100; cdb_val = 32'h1;
        model_reset();
        @(posedge clk_in);
        #1;
        check("rst_nb", need_branch, 0);
        check("rst_ba", branch_addr, 0);
        check("rst_full", bp_full, 0);
        check("rst_pf", predict_fail, 0);
        check("rst_fa", fail_addr, 0);
        branch_in = 1'b0; cdb_active = 1'b0;
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
    endtask

    initial begin
        bit          r_rdy, r_br, r_len, r_cdb, r_tk;
        logic [31:0] r_pc, r_imm, r_caddr;

        do_reset();

        // First prediction after reset, then a taken resolution that mispredicts.
        push(32'h100, 32'h20);
        check("r38_nb", o_nb, 0);
        check("r38_ba", o_ba, 32'h104);
        resolve(32'h100, 1);
        check("r38_pf", o_pf, 1);
        check("r38_fa", o_fa, 32'h120);

        // Second taken resolution, then a prediction; then four not-taken.
        push(32'h100, 32'h20);
        resolve(32'h100, 1);
        push(32'h100, 32'h20);
`ifndef GSHARE_GHR_EN
        check("r39_nb", o_nb, 1);
        check("r39_ba", o_ba, 32'h120);
`endif
        resolve(32'h100, 1);
        for (int i = 0; i < 4; i++) begin
            push(32'h100, 32'h20);
            resolve(32'h100, 0);
        end
        push(32'h100, 32'h20);
        resolve(32'h100, 1);
        push(32'h100, 32'h20);
`ifndef GSHARE_GHR_EN
        check("r39_sat", o_nb, 0);
`endif
        resolve(32'h100, 0);

        // Fill the queue, offer a ninth branch, then free one slot.
        do_reset();
        for (int i = 0; i < 8; i++) push(32'h200 + 32'(4 * i), 32'h40);
        push(32'h300, 32'h40);
        check("r40_full", o_full, 1);
        check("r40_nb9", o_nb, 0);
        check("r40_ba9", o_ba, 0);
        resolve(32'h200, 0);
        idle();
        check("r40_free", o_full, 0);

        // Full with a hit and a branch together: push stays blocked.
        push(32'h320, 32'h40);
        step(1, 1, 32'h330, 32'h40, 1, 1, 32'h204, 0);
        check("r42_blk_full", o_full, 1);
        check("r42_blk_ba", o_ba, 0);
        idle();
        check("r42_after", o_full, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 32'h340, 32'h40, 1, 1, 32'h208, 1);
            check("r42_rdy_pf", o_pf, 0);
        end
        push(32'h350, 32'h40);
        idle();
        check("r42_frozen", o_full, 1);

        // Three in flight, head mispredicts, stale broadcasts ignored.
        do_reset();
        push(32'h400, 32'h80);
        push(32'h404, 32'h80);
        push(32'h408, 32'h80);
        step(1, 1, 32'h40c, 32'h80, 1, 1, 32'h400, 1);
        check("r41_pf", o_pf, 1);
        check("r41_fa", o_fa, 32'h480);
        resolve(32'h404, 0);
        check("r41_stale", o_pf, 0);
        resolve(32'h40c, 1);
        check("r41_dropped", o_pf, 0);
        push(32'h400, 32'h80);
        resolve(32'h400, 1);

        // Asynchronous reset between edges with entries in flight.
        push(32'h500, 32'h10);
        push(32'h504, 32'h10);
        rdy_in = 1'b1; branch_in = 1'b1; pc_in = 32'h508; imm_in = 32'h10;
        cdb_active = 1'b1; cdb_addr = 32'h500; cdb_val = 32'h1;
        #2;
        rst_in = 1'b0;
        #1;
        check("r43_nb", need_branch, 0);
        check("r43_ba", branch_addr, 0);
        check("r43_pf", predict_fail, 0);
        check("r43_fa", fail_addr, 0);
        model_reset();
        branch_in = 1'b0; cdb_active = 1'b0;
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        resolve(32'h500, 1);
        check("r43_silent", o_pf, 0);
        push(32'h500, 32'h10);
        check("r43_weak", o_nb, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r_rdy = ($urandom_range(0, 9) != 0);
            r_br  = ($urandom_range(0, 1) != 0);
            r_pc  = 32'h1000 + 32'($urandom_range(0, 127) << 1);
            r_imm = $urandom();
            r_len = ($urandom_range(0, 1) != 0);
            r_cdb = ($urandom_range(0, 99) < 35);
            if (m_q.size() > 0 && $urandom_range(0, 3) != 0) r_caddr = m_q[0].pc;
            else r_caddr = r_pc ^ 32'h8;
            r_tk  = ($urandom_range(0, 9) < (r_caddr[2] ? 8 : 2));
            step(r_rdy, r_br, r_pc, r_imm, r_len, r_cdb, r_caddr, r_tk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gshare_predictor.md
GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 BHT_IDX_W, 6, pattern table holds 2^BHT_IDX_W saturating counters.
REQ-002 CTR_W, 2, counter width, legal range 2..4.
REQ-003 GHR_W, 6, global history length, legal range 1..BHT_IDX_W.
REQ-004 Q_DEPTH_W, 3, in-flight queue holds 2^Q_DEPTH_W entries.
REQ-005 clk_in  in  1  sole clock, rising edge.
REQ-006 rst_in  in  1  asynchronous, active-low reset.
REQ-007 rdy_in  in  1  global enable; low freezes all state.
REQ-008 branch_in  in  1  decoded conditional branch present at pc_in.
REQ-009 pc_in  in  32  address of that branch.
REQ-010 imm_in  in  32  sign-extended branch offset.
REQ-011 inst_length_in  in  1  1 = 4-byte instruction, 0 = 2-byte.
REQ-012 cdb_active  in  1  CDB broadcast valid.
REQ-013 cdb_addr  in  32  source PC of the broadcast.
REQ-014 cdb_val  in  32  result; bit 0 = branch actually taken.
REQ-015 need_branch  out  1  predicted taken.
REQ-016 branch_addr  out  32  predicted next PC.
REQ-017 bp_full  out  1  queue full; fetch SHALL stall and re-present the branch.
REQ-018 predict_fail  out  1  head prediction wrong.
REQ-019 fail_addr  out  32  corrected PC while predict_fail is high, else 0.

Function
REQ-020 idx = pc_in[BHT_IDX_W:1] XOR ghr, with ghr zero-extended to BHT_IDX_W bits.
REQ-021 accept = branch_in && rdy_in && !bp_full; need_branch = accept && ctr[idx][CTR_W-1], combinational, zero latency.
REQ-022 branch_addr = accept ? (need_branch ? pc_in+imm_in : pc_in+offset) : 0, with offset = 4 or 2; all 32-bit adds wrap modulo 2^32.
REQ-023 bp_full = (count == 2^Q_DEPTH_W), where count is a registered value Q_DEPTH_W+1 bits wide; a branch offered while full is not pushed and sees zero outputs.
REQ-024 On accept, at posedge: push {pc, alternate addr, pred, idx, ghr snapshot}; rear wraps at 2^Q_DEPTH_W; ghr <= {ghr[GHR_W-2:0], need_branch}.
REQ-025 hit = cdb_active && count != 0 && cdb_addr == head.pc; non-matching broadcasts are ignored.
REQ-026 On hit: counter at head.idx increments (taken) or decrements (not taken), saturating at 2^CTR_W-1 and 0; head pops.
REQ-027 predict_fail = hit && head.pred != cdb_val[0], combinational; fail_addr = head.alt.
REQ-028 On predict_fail, at posedge: queue flushed (front = rear = count = 0); ghr <= {head.ghr[GHR_W-2:0], cdb_val[0]}; any same-cycle push and its ghr shift are discarded; the counter update still occurs.
REQ-029 Push and correct hit in the same cycle: count unchanged, both pointers advance; when full, the push stays blocked that cycle.
REQ-030 A prediction reading an index updated in the same cycle uses the pre-update counter value.
REQ-031 rdy_in low: no push, pop, counter or ghr change; need_branch, branch_addr and predict_fail read 0.

Reset
REQ-032 rst_in low asynchronously sets every counter to 2^(CTR_W-1)-1 (weakly not taken), clears ghr, pointers, count and entries, and forces all outputs to 0.
REQ-033 Reset mid-operation drops all in-flight entries silently; no predict_fail is raised for them.

Configuration
REQ-034 GSHARE_GHR_EN defined: index per REQ-020, with history speculation and restore.
REQ-035 GSHARE_GHR_EN undefined: idx = pc_in[BHT_IDX_W:1] (bimodal); the ghr register and snapshot field are absent; a failure only flushes the queue.

Structure
REQ-036 Package bp_pkg SHALL hold default parameters, the queue-entry struct typedef, counter init/threshold constants and PC offset constants.
REQ-037 Sub-module bp_inflight_fifo SHALL implement the circular queue with push, pop, flush, count, full and empty.

Verification
REQ-038 After reset, branch pc 0x100, imm 0x20, length 1 -> need_branch=0, branch_addr=0x104; CDB 0x100 with val 1 -> predict_fail=1, fail_addr=0x120.
REQ-039 Bimodal build, CTR_W=2: two taken resolutions at 0x100 -> next prediction need_branch=1, branch_addr=0x120; four not-taken resolutions -> counter saturates at 0.
REQ-040 Eight pushes with no resolution -> bp_full=1; ninth branch -> zero outputs, no push; one hit -> bp_full=0 the next cycle.
REQ-041 Three in flight, head mispredicts -> predict_fail for one cycle, count=0 next cycle, ghr = head snapshot shifted by the actual outcome; later CDB for the flushed PCs is ignored.
REQ-042 Full queue with hit and branch_in in the same cycle -> push rejected; rdy_in low for 5 cycles with a CDB hit -> no state change.
REQ-043 rst_in asserted between clock edges mid-flight -> outputs 0 immediately; counters read weakly not taken afterwards.
